code_fetch: RTL and testbench

Instruction fetch sequencer that reads the 128x32 code RAM on behalf of the core decoder. It owns the program counter and drives the RAM address with write-enable held low. It absorbs the RAM's 1-cycle read latency and presents instructions on a valid/ready interface. It supports start, redirect (branch/flush) and end-of-code detection.

---
 rtl/code_fetch_pkg.sv | 29 ++
 rtl/code_fetch_fifo.sv | 77 +++++++
 rtl/code_fetch.sv | 139 +++++++++++++
 tb/tb_code_fetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : code_fetch_pkg
//  Description : Shared types and default parameters for the code fetch
//                sequencer and its instruction FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package code_fetch_pkg;

    localparam int CF_AW       = 7;    // code RAM address width (128 words)
    localparam int CF_DW       = 32;   // instruction width
    localparam int CF_DEPTH    = 2;    // output FIFO depth
    localparam int CF_START_PC = 0;    // PC loaded on start

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_END  = 2'd2
    } state_t;

    // One FIFO entry: instruction and the address it was fetched from
    typedef struct packed {
        logic [CF_AW-1:0] pc;
        logic [CF_DW-1:0] data;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/code_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : DEPTH-entry synchronous FIFO with push, pop, flush, occupancy
//                count and a registered head. Push and pop may coincide.
//                A push into a full FIFO without a pop is dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [CW-1:0] o_count,
    output logic          o_valid,
    output logic [W-1:0]  o_head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] C_LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] C_FULL     = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_pop;
    logic          w_do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != C_FULL) || w_do_pop);

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; flush empties without touching storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/code_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : code_fetch
//  Description : Instruction fetch sequencer for the 128x32 code RAM. Owns the
//                PC, absorbs the RAM's one-cycle read latency and delivers
//                {pc, instruction} on a valid/ready interface. Supports start,
//                redirect (branch/flush) and end-of-code detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module code_fetch
    import code_fetch_pkg::*;
#(
    parameter int AW       = CF_AW,
    parameter int DW       = CF_DW,
    parameter int DEPTH    = CF_DEPTH,
    parameter int START_PC = CF_START_PC
) (
    input  logic          mclk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_rdata,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst_data,
    output logic [AW-1:0] inst_pc,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = CW + 1;          // wide enough for DEPTH + 2
    localparam int EW = AW + DW;
    localparam logic [AW-1:0] C_LAST_PC  = {AW{1'b1}};
    localparam logic [AW-1:0] C_START_PC = AW'(START_PC);

    state_t        r_state;
    logic [AW-1:0] r_fetch_pc;
    logic [AW-1:0] r_v1_pc;      // address of the read currently in flight
    logic          r_v1;         // a RAM read is in flight this cycle
    logic          r_done;

    logic [CW-1:0] w_count;
    logic [EW-1:0] w_head;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [KW-1:0] w_need;
    logic [KW-1:0] w_avail;
    logic [KW-1:0] w_count_next;
    logic          w_done_next;

    // Code RAM is read-only from this block
    assign ram_we   = 1'b0;
    assign ram_addr = r_fetch_pc;

    assign w_pop  = inst_valid && inst_ready;
    // A redirect kills the in-flight read so it never reaches the FIFO
    assign w_push = r_v1 && !redirect_valid;

    // Credit check: FIFO entries plus the in-flight read plus this new read
    // must fit, counting the slot freed by a same-cycle pop
    assign w_need  = KW'(w_count) + KW'(r_v1) + KW'(1);
    assign w_avail = KW'(DEPTH) + KW'(w_pop);
    assign w_issue = (r_state == ST_RUN) && !redirect_valid && (w_need <= w_avail);

    // Occupancy after this edge; drives the registered done flag
    assign w_count_next = KW'(w_count) + KW'(w_push) - KW'(w_pop);
    assign w_done_next  = (r_state == ST_END) && !redirect_valid && (w_count_next == '0);

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

    // Sequencer: state, PC, in-flight tracking and done flag
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= C_START_PC;
            r_v1       <= 1'b0;
            r_v1_pc    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_v1   <= w_issue;
            r_done <= w_done_next;
            if (w_issue) begin
                r_v1_pc <= r_fetch_pc;
            end
            if (redirect_valid) begin
                r_state    <= ST_RUN;
                r_fetch_pc <= redirect_pc;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state    <= ST_RUN;
                            r_fetch_pc <= C_START_PC;
                        end
                    end
                    ST_RUN: begin
                        if (w_issue) begin
                            // Last word: stop here rather than wrap to 0
                            if (r_fetch_pc == C_LAST_PC) begin
                                r_state <= ST_END;
                            end else begin
                                r_fetch_pc <= r_fetch_pc + AW'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (mclk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data ({r_v1_pc, ram_rdata}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_count     (w_count),
        .o_valid     (inst_valid),
        .o_head      (w_head)
    );

    assign inst_pc   = w_head[EW-1:DW];
    assign inst_data = w_head[DW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_code_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_code_fetch
//  Description : Self-checking bench for code_fetch. A delivery-order model
//                (next expected pc, busy/done flags) is checked every cycle;
//                directed scenarios pin the model with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_code_fetch;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          mclk           = 1'b0;
    logic          rst_n          = 1'b0;
    logic          start          = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc    = '0;
    logic          inst_ready     = 1'b1;
    logic [DW-1:0] ram_rdata      = '0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic          inst_valid;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [128];

    int n_pass  = 0;
    int n_total = 0;

    code_fetch dut (
        .mclk           (mclk),
        .rst_n          (rst_n),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_rdata      (ram_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .busy           (busy),
        .done           (done)
    );

    always #5 mclk = ~mclk;

    // Synchronous-read code RAM: data for an address appears the next cycle
    always @(posedge mclk) ram_rdata <= mem[ram_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int            m_exp   = 0;     // next pc that must be delivered (128 = none)
    logic          m_busy  = 1'b0;
    logic          m_done  = 1'b0;
    logic          m_kill  = 1'b0;  // cycle right after a redirect
    logic          p_hold  = 1'b0;  // previous cycle stalled with valid head
    logic [AW-1:0] p_pc    = '0;
    logic [DW-1:0] p_data  = '0;
    logic [DW-1:0] m_data;

    always @(negedge mclk) begin
        if (!rst_n) begin
            m_exp  = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_kill = 1'b0;
            p_hold = 1'b0;
        end else begin
            chk("ram_we", 64'(ram_we), 64'd0);
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("fifo_bound", 64'(dut.w_count <= DEPTH), 64'd1);
            if (m_kill) chk("valid_after_redirect", 64'(inst_valid), 64'd0);
            if (p_hold) begin
                chk("hold_valid", 64'(inst_valid), 64'd1);
                chk("hold_pc", 64'(inst_pc), 64'(p_pc));
                chk("hold_data", 64'(inst_data), 64'(p_data));
            end
            if (inst_valid && inst_ready) begin
                m_data = 32'hA000_0000 + 32'(m_exp);
                chk("deliver_in_range", 64'(m_exp <= 127), 64'd1);
                chk("deliver_pc", 64'(inst_pc), 64'(m_exp));
                chk("deliver_data", 64'(inst_data), 64'(m_data));
                m_exp++;
            end
            p_hold = inst_valid && !inst_ready && !redirect_valid;
            p_pc   = inst_pc;
            p_data = inst_data;
            m_kill = 1'b0;
            if (redirect_valid) begin
                m_exp  = int'(redirect_pc);
                m_busy = 1'b1;
                m_kill = 1'b1;
            end else if (start && !m_busy) begin
                m_exp  = 0;
                m_busy = 1'b1;
            end
            m_done = m_busy && !redirect_valid && (m_exp == 128);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic pulse_redirect(input logic [AW-1:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_head(input int pc, input int max, input string name);
        int k = 0;
        while (!(inst_valid && int'(inst_pc) == pc) && k < max) begin
            tick();
            k++;
        end
        chk(name, 64'(inst_valid && int'(inst_pc) == pc), 64'd1);
    endtask

    task automatic wait_done(input int max, input string name);
        int k = 0;
        while (!done && k < max) begin
            tick();
            k++;
        end
        chk(name, 64'(done), 64'd1);
    endtask

    // First cycle (1 = cycle after the request) at which inst_valid is high
    task automatic first_valid(input int max, output int k_out,
                               output logic [AW-1:0] pc, output logic [DW-1:0] d);
        int k = 1;
        k_out = -1;
        pc    = '0;
        d     = '0;
        while (k_out < 0 && k <= max) begin
            if (inst_valid) begin
                k_out = k;
                pc    = inst_pc;
                d     = inst_data;
            end else begin
                tick();
                k++;
            end
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int            k;
        int            first_k;
        int            last_k;
        int            n_del;
        logic [AW-1:0] fpc;
        logic [DW-1:0] fdat;

        for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + 32'(i);

        // Reset values
        repeat (3) tick();
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_inst_pc", 64'(inst_pc), 64'd0);
        chk("rst_inst_data", 64'(inst_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // Full stream from start; an extra start mid-run must be ignored
        start   = 1'b1;
        first_k = -1;
        last_k  = -1;
        k       = 0;
        while (last_k < 0 && k < 300) begin
            tick();
            k++;
            start = (k == 50);
            if (inst_valid && inst_ready) begin
                if (first_k < 0) first_k = k;
                if (inst_pc == 7'd127) last_k = k;
            end
        end
        start = 1'b0;
        chk("stream_first_valid_cycle", 64'(first_k), 64'd3);
        chk("stream_last_cycle", 64'(last_k), 64'd130);
        chk("stream_done_not_yet", 64'(done), 64'd0);
        tick();
        chk("stream_done_after_last", 64'(done), 64'd1);

        // End boundary: redirect to the last word from END
        pulse_redirect(7'd127);
        n_del = 0;
        for (int i = 0; i < 10; i++) begin
            if (inst_valid && inst_ready) begin
                n_del++;
                chk("end_pc", 64'(inst_pc), 64'd127);
            end
            tick();
        end
        chk("end_deliveries", 64'(n_del), 64'd1);
        chk("end_done", 64'(done), 64'd1);
        chk("end_ram_addr_no_wrap", 64'(ram_addr), 64'd127);

        // Backpressure at pc 20 for 5 cycles
        pulse_redirect(7'd0);
        wait_head(20, 50, "bp_reach_pc20");
        inst_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("bp_hold_pc20", 64'(inst_pc), 64'd20);
        end
        chk("bp_ram_stalled", 64'(ram_addr), 64'd22);
        tick();
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_release_valid", 64'(inst_valid), 64'd1);
            chk("bp_release_pc", 64'(inst_pc), 64'(20 + i));
            tick();
        end

        // Redirect while head is pc 10
        pulse_redirect(7'd0);
        wait_head(10, 50, "rd_reach_pc10");
        pulse_redirect(7'h40);
        first_valid(10, first_k, fpc, fdat);
        chk("rd_first_cycle", 64'(first_k), 64'd3);
        chk("rd_first_pc", 64'(fpc), 64'h40);
        chk("rd_first_data", 64'(fdat), 64'hA000_0040);
        wait_done(200, "rd_done");

        // Asynchronous reset in the middle of a cycle while running
        pulse_redirect(7'h60);
        repeat (8) tick();
        @(posedge mclk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("mid_rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_inst_pc", 64'(inst_pc), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_busy", 64'(busy), 64'd0);

        // Redirect from IDLE behaves as a start at the redirect target
        pulse_redirect(7'd5);
        first_valid(10, first_k, fpc, fdat);
        chk("idle_rd_first_cycle", 64'(first_k), 64'd3);
        chk("idle_rd_first_pc", 64'(fpc), 64'd5);
        chk("idle_rd_first_data", 64'(fdat), 64'hA000_0005);
        wait_done(200, "idle_rd_done");
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
